dial_spinner: RTL

Multi-channel rotary dial/spinner emulator for the arcade input path. It converts digital left/right holds and signed relative deltas (mouse or analog) into free-running, wrap-around dial counts, one per player. It generalises the single-channel fixed 5-bit Moon War dial with parametrised channel count, count width, repeat rate and hold acceleration. It sits between the joystick/keyboard mapping and the per-game input-port multiplexer that feeds the CPU board.

---
 rtl/dial_spinner.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dial_spinner.sv
// dial_spinner: multi-channel rotary dial emulator driven by left/right holds (with repeat
// acceleration) and signed relative deltas. Define DIAL_QUAD_EN to drive Gray-coded quad outputs.
module dial_spinner #(
  parameter int          CHANNELS    = 2,
  parameter int          WIDTH       = 5,
  parameter logic [15:0] STEP_DIV    = 16'd4096,
  parameter int          ACCEL_STEPS = 8,
  parameter int          ACCEL_MAX   = 4
) (
  input  logic                                           clk,
  input  logic                                           RESET,
  input  logic                                           ce,
  input  logic [CHANNELS-1:0]                            move_left,
  input  logic [CHANNELS-1:0]                            move_right,
  input  logic                                           delta_valid,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] delta_ch,
  input  logic [7:0]                                     delta,
  output logic [CHANNELS*WIDTH-1:0]                      dial_out,
  output logic [CHANNELS-1:0]                            dir_out,
  output logic [CHANNELS-1:0]                            quad_a,
  output logic [CHANNELS-1:0]                            quad_b,
  output logic [2*CHANNELS-1:0]                          dbg_state
);

  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int NW = WIDTH + 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_BLOCK = 2'd2;

  localparam logic [15:0]      RELOAD  = STEP_DIV - 16'd1;
  localparam logic [15:0]      ACC_N   = 16'(ACCEL_STEPS);
  localparam logic [WIDTH-1:0] SPD_MAX = WIDTH'(ACCEL_MAX);
  localparam logic [WIDTH-1:0] SPD_ONE = WIDTH'(1);

  // delta_valid is a single-cycle strobe qualifying delta_ch/delta; it is always accepted
  // (no ready/backpressure), and a strobe addressing a nonexistent channel is dropped.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [1:0]        r_state;
    logic              r_hdir;
    logic [15:0]       r_timer;
    logic [WIDTH-1:0]  r_speed;
    logic [15:0]       r_sas;
    logic [WIDTH-1:0]  r_count;
    logic              r_dir;

    logic [1:0]        w_state_nx;
    logic              w_hdir_nx;
    logic [15:0]       w_timer_nx;
    logic [WIDTH-1:0]  w_speed_nx;
    logic [15:0]       w_sas_nx;
    logic [WIDTH-1:0]  w_mag;
    logic [NW-1:0]     w_mag_ext;
    logic [NW-1:0]     w_step;
    logic [NW-1:0]     w_dext;
    logic [NW-1:0]     w_net;
    logic [WIDTH-1:0]  w_count_nx;
    logic              w_l;
    logic              w_r;

    assign w_l = move_left[g];
    assign w_r = move_right[g];

    always_comb begin
      w_state_nx = r_state;
      w_hdir_nx  = r_hdir;
      w_timer_nx = r_timer;
      w_speed_nx = r_speed;
      w_sas_nx   = r_sas;
      w_mag      = '0;
      case (r_state)
        ST_IDLE: begin
          if (w_l && w_r) begin
            w_state_nx = ST_BLOCK;
          end else if (w_l ^ w_r) begin
            w_state_nx = ST_HOLD;
            w_hdir_nx  = w_r;
            w_mag      = SPD_ONE;
            w_timer_nx = RELOAD;
            w_speed_nx = SPD_ONE;
            w_sas_nx   = '0;
          end
        end
        ST_HOLD: begin
          if (w_l && w_r) begin
            w_state_nx = ST_BLOCK;
            w_timer_nx = '0;
            w_speed_nx = SPD_ONE;
            w_sas_nx   = '0;
          end else if (!w_l && !w_r) begin
            w_state_nx = ST_IDLE;
            w_timer_nx = '0;
            w_speed_nx = SPD_ONE;
            w_sas_nx   = '0;
          end else if (w_r != r_hdir) begin
            // reversal restarts acceleration with an immediate single step
            w_hdir_nx  = w_r;
            w_mag      = SPD_ONE;
            w_timer_nx = RELOAD;
            w_speed_nx = SPD_ONE;
            w_sas_nx   = '0;
          end else if (ce) begin
            if (r_timer == 16'd0) begin
              w_mag      = r_speed;
              w_timer_nx = RELOAD;
              if (r_sas + 16'd1 == ACC_N) begin
                w_sas_nx = '0;
                if (r_speed < SPD_MAX) w_speed_nx = r_speed + SPD_ONE;
              end else begin
                w_sas_nx = r_sas + 16'd1;
              end
            end else begin
              w_timer_nx = r_timer - 16'd1;
            end
          end
        end
        ST_BLOCK: begin
          if (!(w_l && w_r)) w_state_nx = ST_IDLE;
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end

    // button step and delta are merged into one signed net change
    assign w_mag_ext  = {{(NW-WIDTH){1'b0}}, w_mag};
    assign w_step     = w_hdir_nx ? w_mag_ext : (~w_mag_ext + 1'b1);
    assign w_dext     = (delta_valid && (delta_ch == CW'(g))) ? {{(NW-8){delta[7]}}, delta} : '0;
    assign w_net      = w_step + w_dext;
    assign w_count_nx = r_count + w_net[WIDTH-1:0];

    always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
        r_state <= ST_IDLE;
        r_hdir  <= 1'b1;
        r_timer <= '0;
        r_speed <= SPD_ONE;
        r_sas   <= '0;
        r_count <= '0;
        r_dir   <= 1'b1;
      end else begin
        r_state <= w_state_nx;
        r_hdir  <= w_hdir_nx;
        r_timer <= w_timer_nx;
        r_speed <= w_speed_nx;
        r_sas   <= w_sas_nx;
        r_count <= w_count_nx;
        if (w_net != '0) r_dir <= ~w_net[NW-1];
      end
    end

`ifdef DIAL_QUAD_EN
    logic r_qa;
    logic r_qb;
    always_ff @(posedge clk or posedge RESET) begin
      if (RESET) begin
        r_qa <= 1'b0;
        r_qb <= 1'b0;
      end else begin
        r_qa <= w_count_nx[1];
        r_qb <= w_count_nx[1] ^ w_count_nx[0];
      end
    end
    assign quad_a[g] = r_qa;
    assign quad_b[g] = r_qb;
`else
    assign quad_a[g] = 1'b0;
    assign quad_b[g] = 1'b0;
`endif

    assign dial_out[g*WIDTH +: WIDTH] = r_count;
    assign dir_out[g]                 = r_dir;
    assign dbg_state[2*g +: 2]        = r_state;
  end

endmodule
